// File: rtl/rgb_menu_ctrl.sv
// Front-panel menu controller for one RGB PWM colour block.
// Five raw buttons are synchronised, debounced and edge-detected. A small menu
// FSM then drives the block's enable, colour index and colour-confirm strobe.
module rgb_menu_ctrl #(
   parameter int unsigned DB_CYCLES   = 1_000_000,
   parameter int unsigned NUM_COLORS  = 13,
   parameter int unsigned AUTO_PERIOD = 200_000_000
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       btn_pwr,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_sel,
   input  logic       btn_auto,
   output logic       en,
   output logic [3:0] cmode_colorch,
   output logic       cmode_btn0,
   output logic [2:0] state_o
);

   localparam int unsigned NUM_BTN = 5;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int unsigned TMR_W   = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COLORS - 1);

   // Bit positions of each button in the packed button vectors
   localparam int unsigned B_PWR  = 0;
   localparam int unsigned B_SEL  = 1;
   localparam int unsigned B_AUTO = 2;
   localparam int unsigned B_NEXT = 3;
   localparam int unsigned B_PREV = 4;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_BROWSE = 3'd1,
      ST_APPLY  = 3'd2,
      ST_RUN    = 3'd3,
      ST_AUTO   = 3'd4
   } state_e;

   logic [NUM_BTN-1:0]           raw_c;
   logic [NUM_BTN-1:0]           sync1_q;
   logic [NUM_BTN-1:0]           sync2_q;
   logic [NUM_BTN-1:0]           db_q;
   logic [NUM_BTN-1:0]           db_d;
   logic [NUM_BTN-1:0]           db_dly_q;
   logic [NUM_BTN-1:0][DB_W-1:0] cnt_q;
   logic [NUM_BTN-1:0][DB_W-1:0] cnt_d;
   logic [NUM_BTN-1:0]           press_c;

   logic pwr_c;
   logic sel_c;
   logic auto_c;
   logic next_c;
   logic prev_c;

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_inc_c;
   logic [IDX_W-1:0] idx_dec_c;
   logic [TMR_W-1:0] timer_q;
   logic             en_q;
   logic [IDX_W-1:0] colorch_q;
   logic             btn0_q;

   assign raw_c = {btn_prev, btn_next, btn_auto, btn_sel, btn_pwr};

   // Two-flop synchronisers for the asynchronous raw buttons
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_c;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: count consecutive cycles of disagreement, flip level on the last one
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      for (int b = 0; b < NUM_BTN; b++) begin
         if (sync2_q[b] != db_q[b]) begin
            if (cnt_q[b] == DB_LAST) begin
               db_d[b] = ~db_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + DB_W'(1);
            end
         end
      end
   end

   // Debounce state and one-cycle-delayed level for edge detection
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q    <= '0;
         db_q     <= '0;
         db_dly_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         db_q     <= db_d;
         db_dly_q <= db_q;
      end
   end

   assign press_c = db_q & ~db_dly_q;

   // Fixed priority pwr > sel > auto > next > prev; next+prev together cancel
   assign pwr_c  = press_c[B_PWR];
   assign sel_c  = press_c[B_SEL]  & ~pwr_c;
   assign auto_c = press_c[B_AUTO] & ~pwr_c & ~press_c[B_SEL];
   assign next_c = press_c[B_NEXT] & ~press_c[B_PREV] & ~pwr_c & ~press_c[B_SEL] & ~press_c[B_AUTO];
   assign prev_c = press_c[B_PREV] & ~press_c[B_NEXT] & ~pwr_c & ~press_c[B_SEL] & ~press_c[B_AUTO];

   // Wrapping colour index steps
   assign idx_inc_c = (idx_q >= IDX_LAST) ? '0 : idx_q + IDX_W'(1);
   assign idx_dec_c = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);

   // Menu FSM with registered outputs; the strobe defaults low every cycle
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= ST_OFF;
         idx_q     <= '0;
         timer_q   <= '0;
         en_q      <= 1'b0;
         colorch_q <= '0;
         btn0_q    <= 1'b0;
      end else begin
         btn0_q <= 1'b0;
         if (pwr_c && (state_q != ST_OFF)) begin
            // Power-off wins over everything, including a same-cycle auto strobe
            state_q   <= ST_OFF;
            idx_q     <= '0;
            timer_q   <= '0;
            en_q      <= 1'b0;
            colorch_q <= '0;
         end else begin
            case (state_q)
               ST_OFF: begin
                  en_q <= 1'b0;
                  if (pwr_c) begin
                     state_q   <= ST_BROWSE;
                     idx_q     <= '0;
                     colorch_q <= '0;
                     en_q      <= 1'b1;
                  end
               end
               ST_BROWSE: begin
                  if (sel_c) begin
                     state_q   <= ST_APPLY;
                     btn0_q    <= 1'b1;
                     colorch_q <= idx_q;
                  end else if (next_c) begin
                     idx_q     <= idx_inc_c;
                     colorch_q <= idx_inc_c;
                  end else if (prev_c) begin
                     idx_q     <= idx_dec_c;
                     colorch_q <= idx_dec_c;
                  end
               end
               ST_APPLY: begin
                  state_q <= ST_RUN;
               end
               ST_RUN: begin
                  if (sel_c) begin
                     state_q <= ST_RUN;
                  end else if (auto_c) begin
                     state_q <= ST_AUTO;
                     timer_q <= '0;
                  end else if (next_c) begin
                     state_q   <= ST_BROWSE;
                     idx_q     <= idx_inc_c;
                     colorch_q <= idx_inc_c;
                  end else if (prev_c) begin
                     state_q   <= ST_BROWSE;
                     idx_q     <= idx_dec_c;
                     colorch_q <= idx_dec_c;
                  end
               end
               ST_AUTO: begin
                  if (sel_c || next_c || prev_c) begin
                     state_q <= ST_RUN;
                     timer_q <= '0;
                  end else if (timer_q == TMR_LAST) begin
                     timer_q   <= '0;
                     idx_q     <= idx_inc_c;
                     colorch_q <= idx_inc_c;
                     btn0_q    <= ~btn0_q;
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end
               default: begin
                  // Unused encodings fall back to a clean OFF
                  state_q   <= ST_OFF;
                  idx_q     <= '0;
                  timer_q   <= '0;
                  en_q      <= 1'b0;
                  colorch_q <= '0;
               end
            endcase
         end
      end
   end

   assign en            = en_q;
   assign cmode_colorch = colorch_q;
   assign cmode_btn0    = btn0_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_rgb_menu_ctrl.sv
// Directed bench for rgb_menu_ctrl with short debounce and auto periods.
module tb_rgb_menu_ctrl;

   logic       clk = 1'b0;
   logic       nrst;
   logic       btn_pwr;
   logic       btn_next;
   logic       btn_prev;
   logic       btn_sel;
   logic       btn_auto;
   logic       en;
   logic [3:0] cmode_colorch;
   logic       cmode_btn0;
   logic [2:0] state_o;

   int checks   = 0;
   int failures = 0;
   int strobes;

   rgb_menu_ctrl #(
      .DB_CYCLES  (4),
      .NUM_COLORS (13),
      .AUTO_PERIOD(16)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .btn_pwr      (btn_pwr),
      .btn_next     (btn_next),
      .btn_prev     (btn_prev),
      .btn_sel      (btn_sel),
      .btn_auto     (btn_auto),
      .en           (en),
      .cmode_colorch(cmode_colorch),
      .cmode_btn0   (cmode_btn0),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   // Advance n clock edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Button mask bits: 0 pwr, 1 sel, 2 auto, 3 next, 4 prev
   task automatic set_btns(input logic [4:0] m);
      {btn_prev, btn_next, btn_auto, btn_sel, btn_pwr} = m;
   endtask

   task automatic press(input logic [4:0] m, input int hold, input int gap);
      set_btns(m);
      tick(hold);
      set_btns(5'b0);
      tick(gap);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Count strobe cycles over n ticks
   task automatic watch(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (cmode_btn0 === 1'b1) cnt++;
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset, then power on with exact latency
      nrst = 1'b0;
      set_btns(5'b0);
      tick(3);
      chk("rst_held_state", 8'(state_o), 8'd0);
      nrst = 1'b1;
      tick(2);
      chk("rst_en", 8'(en), 8'd0);
      chk("rst_colorch", 8'(cmode_colorch), 8'd0);
      chk("rst_btn0", 8'(cmode_btn0), 8'd0);
      chk("rst_state", 8'(state_o), 8'd0);
      btn_pwr = 1'b1;
      tick(6);
      chk("pwr_lat6_state", 8'(state_o), 8'd0);
      tick(1);
      chk("pwr_lat7_state", 8'(state_o), 8'd1);
      chk("pwr_lat7_en", 8'(en), 8'd1);
      tick(3);
      btn_pwr = 1'b0;
      tick(10);
      chk("pwr_release_state", 8'(state_o), 8'd1);

      // 2: browse with wrap, then apply
      press(5'b10000, 8, 8);
      chk("prev_wrap_colorch", 8'(cmode_colorch), 8'd12);
      chk("browse_btn0_low", 8'(cmode_btn0), 8'd0);
      press(5'b01000, 8, 8);
      chk("next_wrap_colorch", 8'(cmode_colorch), 8'd0);
      press(5'b01000, 8, 8);
      chk("next2_colorch", 8'(cmode_colorch), 8'd1);
      btn_sel = 1'b1;
      tick(6);
      chk("sel_pre_btn0", 8'(cmode_btn0), 8'd0);
      tick(1);
      chk("apply_btn0", 8'(cmode_btn0), 8'd1);
      chk("apply_colorch", 8'(cmode_colorch), 8'd1);
      chk("apply_state", 8'(state_o), 8'd2);
      tick(1);
      chk("run_btn0", 8'(cmode_btn0), 8'd0);
      chk("run_state", 8'(state_o), 8'd3);
      tick(2);
      btn_sel = 1'b0;
      tick(10);
      chk("run_hold_colorch", 8'(cmode_colorch), 8'd1);

      // 3: bounce rejected, clean press steps once (RUN -> BROWSE)
      for (int i = 0; i < 4; i++) begin
         btn_next = 1'b1;
         tick(3);
         btn_next = 1'b0;
         tick(2);
      end
      tick(8);
      chk("bounce_state", 8'(state_o), 8'd3);
      chk("bounce_colorch", 8'(cmode_colorch), 8'd1);
      press(5'b01000, 8, 8);
      chk("clean_next_state", 8'(state_o), 8'd1);
      chk("clean_next_colorch", 8'(cmode_colorch), 8'd2);

      // 4: apply idx 12, then auto-cycle
      press(5'b10000, 8, 8);
      press(5'b10000, 8, 8);
      press(5'b10000, 8, 8);
      chk("prev3_colorch", 8'(cmode_colorch), 8'd12);
      press(5'b00010, 8, 8);
      chk("apply12_state", 8'(state_o), 8'd3);
      chk("apply12_colorch", 8'(cmode_colorch), 8'd12);
      btn_auto = 1'b1;
      tick(7);
      chk("auto_state", 8'(state_o), 8'd4);
      tick(1);
      btn_auto = 1'b0;
      tick(14);
      chk("auto_pre1_btn0", 8'(cmode_btn0), 8'd0);
      tick(1);
      chk("auto_s1_btn0", 8'(cmode_btn0), 8'd1);
      chk("auto_s1_colorch", 8'(cmode_colorch), 8'd0);
      tick(1);
      chk("auto_s1_off", 8'(cmode_btn0), 8'd0);
      tick(14);
      chk("auto_pre2_btn0", 8'(cmode_btn0), 8'd0);
      tick(1);
      chk("auto_s2_btn0", 8'(cmode_btn0), 8'd1);
      chk("auto_s2_colorch", 8'(cmode_colorch), 8'd1);
      tick(16);
      chk("auto_s3_btn0", 8'(cmode_btn0), 8'd1);
      chk("auto_s3_colorch", 8'(cmode_colorch), 8'd2);
      btn_sel = 1'b1;
      tick(7);
      chk("auto_sel_state", 8'(state_o), 8'd3);
      chk("auto_sel_colorch", 8'(cmode_colorch), 8'd2);
      tick(1);
      btn_sel = 1'b0;
      watch(30, strobes);
      chk("auto_exit_strobes", 8'(strobes), 8'd0);
      chk("auto_exit_state", 8'(state_o), 8'd3);

      // 5: simultaneous presses
      press(5'b01000, 8, 8);
      chk("to_browse_colorch", 8'(cmode_colorch), 8'd3);
      press(5'b11000, 8, 8);
      chk("nextprev_colorch", 8'(cmode_colorch), 8'd3);
      chk("nextprev_state", 8'(state_o), 8'd1);
      set_btns(5'b00011);
      watch(8, strobes);
      set_btns(5'b0);
      chk("pwrsel_strobes_a", 8'(strobes), 8'd0);
      watch(8, strobes);
      chk("pwrsel_strobes_b", 8'(strobes), 8'd0);
      chk("pwrsel_state", 8'(state_o), 8'd0);
      chk("pwrsel_en", 8'(en), 8'd0);

      // 6: async reset in the middle of an auto period
      press(5'b00001, 8, 8);
      press(5'b01000, 8, 8);
      press(5'b01000, 8, 8);
      press(5'b00010, 8, 8);
      press(5'b00100, 8, 8);
      chk("pre_rst_state", 8'(state_o), 8'd4);
      chk("pre_rst_colorch", 8'(cmode_colorch), 8'd2);
      chk("pre_rst_en", 8'(en), 8'd1);
      nrst = 1'b0;
      #1;
      chk("async_rst_state", 8'(state_o), 8'd0);
      chk("async_rst_en", 8'(en), 8'd0);
      chk("async_rst_colorch", 8'(cmode_colorch), 8'd0);
      chk("async_rst_btn0", 8'(cmode_btn0), 8'd0);
      tick(2);
      nrst = 1'b1;
      watch(40, strobes);
      chk("post_rst_strobes", 8'(strobes), 8'd0);
      chk("post_rst_state", 8'(state_o), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
